// File: rtl/field_set_control.sv
// Set-button controller: turns level buttons into single-cycle increment strobes
// for the clock or alarm counter chain. Define FIELD_SET_AUTOREPEAT_EN for hold/auto-repeat.
module field_set_control #(
    parameter int N_FIELDS      = 3,
    parameter int HOLD_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4
) (
    input  logic                ck,
    input  logic                reset,
    input  logic [N_FIELDS-1:0] btn,
    input  logic                clock_alarm,
    input  logic [N_FIELDS-1:0] carry_in,
    output logic [N_FIELDS-1:0] up_clock,
    output logic [N_FIELDS-1:0] up_alarm
);

`ifdef FIELD_SET_AUTOREPEAT_EN
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LOAD = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLD,
        REPEAT
    } state_t;

    logic [CNT_W-1:0] cnt     [N_FIELDS];
    logic [CNT_W-1:0] cnt_nxt [N_FIELDS];
`else
    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT
    } state_t;
`endif

    state_t              state     [N_FIELDS];
    state_t              state_nxt [N_FIELDS];
    logic [N_FIELDS-1:0] tgt;
    logic [N_FIELDS-1:0] tgt_nxt;
    logic [N_FIELDS-1:0] p;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_FIELDS; i++) begin
                state[i] <= IDLE;
                tgt[i]   <= 1'b1;
`ifdef FIELD_SET_AUTOREPEAT_EN
                cnt[i]   <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < N_FIELDS; i++) begin
                state[i] <= state_nxt[i];
                tgt[i]   <= tgt_nxt[i];
`ifdef FIELD_SET_AUTOREPEAT_EN
                cnt[i]   <= cnt_nxt[i];
`endif
            end
        end
    end

    // Each channel is an independent Moore machine; p depends on registered state only.
    always_comb begin
        for (int i = 0; i < N_FIELDS; i++) begin
            state_nxt[i] = state[i];
            tgt_nxt[i]   = tgt[i];
            p[i]         = 1'b0;
`ifdef FIELD_SET_AUTOREPEAT_EN
            cnt_nxt[i]   = cnt[i];
`endif
            case (state[i])
                IDLE: begin
                    if (btn[i]) begin
                        state_nxt[i] = PULSE;
                        tgt_nxt[i]   = clock_alarm;
                    end
                end
                PULSE: begin
                    p[i] = 1'b1;
`ifdef FIELD_SET_AUTOREPEAT_EN
                    cnt_nxt[i]   = HOLD_LOAD;
                    state_nxt[i] = btn[i] ? HOLD : IDLE;
`else
                    state_nxt[i] = btn[i] ? WAIT : IDLE;
`endif
                end
`ifdef FIELD_SET_AUTOREPEAT_EN
                HOLD: begin
                    if (!btn[i]) begin
                        state_nxt[i] = IDLE;
                    end else if (cnt[i] == CNT_ONE) begin
                        // Enter REPEAT already at 1 so the first repeat lands HOLD_CYCLES after the first pulse.
                        state_nxt[i] = REPEAT;
                        cnt_nxt[i]   = CNT_ONE;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_ONE;
                    end
                end
                REPEAT: begin
                    p[i] = (cnt[i] == CNT_ONE);
                    if (!btn[i]) begin
                        state_nxt[i] = IDLE;
                    end else if (cnt[i] == CNT_ONE) begin
                        cnt_nxt[i] = REPEAT_LOAD;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_ONE;
                    end
                end
`else
                WAIT: begin
                    if (!btn[i]) begin
                        state_nxt[i] = IDLE;
                    end
                end
`endif
                default: begin
                    state_nxt[i] = IDLE;
                end
            endcase
        end
    end

    // Carry stays live through reset; a coincident carry and set pulse merge into one strobe.
    assign up_alarm = p & ~tgt;
    assign up_clock = carry_in | (p & tgt);

endmodule

// File: tb/tb_field_set_control.sv
// Randomised and directed bench for field_set_control, checked against a press-age model.
module tb_field_set_control;

    localparam int N = 3;
    localparam int H = 8;
    localparam int R = 4;
`ifdef FIELD_SET_AUTOREPEAT_EN
    localparam int HOLD_PULSES = 7;
`else
    localparam int HOLD_PULSES = 1;
`endif

    logic         ck = 1'b0;
    logic         reset;
    logic [N-1:0] btn;
    logic         clock_alarm;
    logic [N-1:0] carry_in;
    logic [N-1:0] up_clock;
    logic [N-1:0] up_alarm;

    int check_count = 0;
    int pass_count  = 0;

    bit m_pressed [N];
    int m_age     [N];
    bit m_tgt     [N];

    field_set_control #(
        .N_FIELDS     (N),
        .HOLD_CYCLES  (H),
        .REPEAT_CYCLES(R)
    ) dut (
        .ck         (ck),
        .reset      (reset),
        .btn        (btn),
        .clock_alarm(clock_alarm),
        .carry_in   (carry_in),
        .up_clock   (up_clock),
        .up_alarm   (up_alarm)
    );

    always #5 ck = ~ck;

    // A press is described only by how many edges it has been held and where it was aimed.
    function automatic bit model_pulse(int i);
        if (!m_pressed[i]) return 1'b0;
        if (m_age[i] == 0) return 1'b1;
`ifdef FIELD_SET_AUTOREPEAT_EN
        if (m_age[i] >= H && ((m_age[i] - H) % R) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pressed[i] = 1'b0;
            m_age[i]     = 0;
            m_tgt[i]     = 1'b1;
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (btn[i]) begin
                    if (!m_pressed[i]) begin
                        m_pressed[i] = 1'b1;
                        m_age[i]     = 0;
                        m_tgt[i]     = clock_alarm;
                    end else begin
                        m_age[i]++;
                    end
                end else begin
                    m_pressed[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s at %0t: got %b, expected %b", tag, $time, got, exp);
    endtask

    task automatic checkCycle(input string tag);
        logic [N-1:0] exp_clock;
        logic [N-1:0] exp_alarm;
        for (int i = 0; i < N; i++) begin
            exp_alarm[i] = model_pulse(i) && !m_tgt[i];
            exp_clock[i] = carry_in[i] | (model_pulse(i) && m_tgt[i]);
        end
        checkOutput({tag, ".up_alarm"}, up_alarm, exp_alarm);
        checkOutput({tag, ".up_clock"}, up_clock, exp_clock);
    endtask

    // One clock: model follows the edge, new inputs go in, outputs are checked mid-cycle.
    task automatic applyStimulus(input string tag, input logic [N-1:0] b, input logic ca,
                                 input logic [N-1:0] ci);
        @(posedge ck);
        model_edge();
        #2;
        btn         = b;
        clock_alarm = ca;
        carry_in    = ci;
        #1;
        checkCycle(tag);
    endtask

    task automatic assertResetNow(input string tag);
        reset = 1'b1;
        model_reset();
        #1;
        checkCycle(tag);
    endtask

    int           alarm1_pulses;
    logic [N-1:0] rb;
    logic         rca;

    initial begin
        reset       = 1'b1;
        btn         = '0;
        clock_alarm = 1'b0;
        carry_in    = '0;
        model_reset();
        #3;
        checkCycle("reset");
        carry_in = 3'b101;
        #1;
        checkCycle("reset_carry");
        applyStimulus("reset_hold", 3'b111, 1'b0, 3'b010);
        applyStimulus("reset_hold", 3'b000, 1'b0, 3'b000);
        #2 reset = 1'b0;

        // Tap on the top field aimed at the clock.
        applyStimulus("tap", 3'b100, 1'b1, 3'b000);
        applyStimulus("tap", 3'b100, 1'b1, 3'b000);
        for (int n = 0; n < 4; n++) applyStimulus("tap", 3'b000, 1'b1, 3'b000);

        // Long hold on field 1 aimed at the alarm, carry wiggling underneath.
        alarm1_pulses = 0;
        for (int n = 0; n < 31; n++) begin
            applyStimulus("hold", (n < 30) ? 3'b010 : 3'b000, 1'b0, N'($urandom_range(0, 7)));
            if (up_alarm[1]) alarm1_pulses++;
        end
        checkOutput("hold_pulse_count", N'(alarm1_pulses), N'(HOLD_PULSES));
        for (int n = 0; n < 3; n++) applyStimulus("hold_idle", 3'b000, 1'b0, 3'b000);

        // Target is latched at press time; toggling mid-press must not redirect.
        for (int n = 0; n < 14; n++) applyStimulus("latch", 3'b001, (n < 5), 3'b000);
        applyStimulus("latch", 3'b000, 1'b0, 3'b000);
        applyStimulus("latch", 3'b000, 1'b0, 3'b000);
        for (int n = 0; n < 3; n++) applyStimulus("latch2", 3'b001, 1'b0, 3'b000);
        applyStimulus("latch2", 3'b000, 1'b1, 3'b000);

        // Two fields together with a periodic carry on field 1.
        for (int n = 0; n < 22; n++)
            applyStimulus("simul", (n < 20) ? 3'b011 : 3'b000, 1'b1, (n % 3 == 0) ? 3'b010 : 3'b000);

        // Reset in the middle of a hold, button kept down across release.
        for (int n = 0; n < 10; n++) applyStimulus("rst_mid", 3'b100, 1'b1, 3'b000);
        carry_in = 3'b011;
        assertResetNow("rst_mid_async");
        applyStimulus("rst_mid_in", 3'b100, 1'b1, 3'b001);
        applyStimulus("rst_mid_in", 3'b100, 1'b1, 3'b000);
        #2 reset = 1'b0;
        for (int n = 0; n < 12; n++) applyStimulus("rst_after", 3'b100, 1'b1, 3'b000);
        applyStimulus("rst_after", 3'b000, 1'b1, 3'b000);

        // Random soak: sticky buttons, occasional mode flips and resets.
        rb  = '0;
        rca = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
            if ($urandom_range(0, 4) == 0) rca = ~rca;
            applyStimulus("rand", rb, rca, N'($urandom_range(0, 7)));
            if ($urandom_range(0, 299) == 0) begin
                assertResetNow("rand_rst");
                applyStimulus("rand_rst", rb, rca, N'($urandom_range(0, 7)));
                #2 reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
